// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the UART transmitter (and receiver).
//   tx_state_t  : transmitter FSM state encoding
//   DEF_*       : default frame parameters
//   PARITY_*    : parity-mode constants
//   max_int / cnt_width : elaboration-time helpers for counter sizing
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int DEF_WORD_BITS    = 8;
  localparam int DEF_SAMPLE_TICKS = 16;
  localparam int DEF_STOP_TICKS   = 16;

  localparam int PARITY_MODE_EVEN = 0;
  localparam int PARITY_MODE_ODD  = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width holding values 0..n-1; never below one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_tick_counter.sv
// uart_tx_tick_counter: baud-tick counter with terminal-count output.
//   clk_i, reset_i : clock, async active-low reset
//   clear_i        : synchronous clear to 0 (has priority over tick_i)
//   tick_i         : advance enable (one baud tick)
//   last_i         : terminal value; count wraps to 0 after it
//   tc_o           : high on the tick that completes the period
module uart_tx_tick_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] last_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (tick_i) begin
      if (count_q == last_i) count_q <= '0;
      else                   count_q <= count_q + WIDTH'(1);
    end
  end

  assign tc_o = tick_i && !clear_i && (count_q == last_i);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: oversampled UART transmitter.
//   clk_i, reset_i : clock, async active-low reset
//   baud_tick_i    : one-cycle pulse, SAMPLE_TICKS per bit
//   data_i/valid_i : word to send, accepted when valid_i & ready_o
//   ready_o        : high in IDLE only
//   tx_o           : serial line (registered, idles high)
//   busy_o         : registered, high from the cycle after accept to end of stop
//   tx_done_o      : registered one-cycle pulse at end of stop period
//
// state  | meaning
// IDLE   | line high, accepting a word
// START  | start bit (low), timed from the first tick after accept
// DATA   | data bits LSB-first, one per SAMPLE_TICKS ticks
// PARITY | optional parity bit
// STOP   | line high for STOP_TICKS ticks, then done pulse
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int WORD_BITS    = DEF_WORD_BITS,
  parameter int SAMPLE_TICKS = DEF_SAMPLE_TICKS,
  parameter int STOP_TICKS   = DEF_STOP_TICKS,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = PARITY_MODE_EVEN
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 baud_tick_i,
  input  logic [WORD_BITS-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 tx_done_o
);

  localparam int TICK_W = cnt_width(max_int(SAMPLE_TICKS, STOP_TICKS));
  localparam int BIT_W  = cnt_width(WORD_BITS);

  localparam logic [TICK_W-1:0] SAMPLE_LAST = TICK_W'(SAMPLE_TICKS - 1);
  localparam logic [TICK_W-1:0] STOP_LAST   = TICK_W'(STOP_TICKS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(WORD_BITS - 1);

  tx_state_t             state_q, state_d;
  logic [WORD_BITS-1:0]  shift_q;
  logic                  parity_q;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic                  tx_q, busy_q, done_q;
  logic                  line_cur;
  logic                  handshake;
  logic                  tick_tc;
  logic [TICK_W-1:0]     tick_last;

  assign handshake = valid_i && (state_q == ST_IDLE);
  assign tick_last = (state_q == ST_STOP) ? STOP_LAST : SAMPLE_LAST;

  // Held clear in IDLE, so a tick coinciding with the handshake is not counted.
  uart_tx_tick_counter #(
    .WIDTH (TICK_W)
  ) u_tick_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (state_q == ST_IDLE),
    .tick_i  (baud_tick_i),
    .last_i  (tick_last),
    .tc_o    (tick_tc)
  );

  always_comb begin
    state_d  = state_q;
    line_cur = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (handshake) state_d = ST_START;
      end
      ST_START: begin
        line_cur = 1'b0;
        if (tick_tc) state_d = ST_DATA;
      end
      ST_DATA: begin
        line_cur = shift_q[0];
        if (tick_tc && (bit_cnt_q == BIT_LAST))
          state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        line_cur = parity_q;
        if (tick_tc) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (tick_tc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // tx_o follows the current state one cycle later, so the start bit falls
  // on the edge after the handshake edge.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= line_cur;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_q == ST_STOP) && tick_tc;
      if (handshake) begin
        shift_q   <= data_i;
        parity_q  <= (^data_i) ^ (PARITY_ODD != 0);
        bit_cnt_q <= '0;
      end else if ((state_q == ST_DATA) && tick_tc) begin
        shift_q   <= shift_q >> 1;
        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
      end
    end
  end

  assign ready_o   = (state_q == ST_IDLE);
  assign tx_o      = tx_q;
  assign busy_o    = busy_q;
  assign tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx. Four instances cover
// no parity / even / odd parity and 1, 1.5, 2 stop-bit periods; all
// share clock, reset, baud tick and data, each has its own valid_i.
module tb_uart_tx;

  localparam int DIV = 4;
  localparam int ST  = 16;
  localparam int PE [4] = '{0, 1, 1, 0};
  localparam int PO [4] = '{0, 0, 1, 0};
  localparam int SP [4] = '{16, 16, 24, 32};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] data = 8'h00;
  logic [3:0] valid = 4'b0;
  logic [3:0] ready, tx, busy, done;

  int vectors = 0;
  int miscompares = 0;
  int div_cnt = 0;

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      div_cnt   = (div_cnt + 1) % DIV;
      baud_tick = (div_cnt == 0);
    end
  end

  uart_tx #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_TICKS(16)) dut0 (
    .clk_i(clk), .reset_i(rst_n), .baud_tick_i(baud_tick), .data_i(data),
    .valid_i(valid[0]), .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]),
    .tx_done_o(done[0]));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_TICKS(16)) dut1 (
    .clk_i(clk), .reset_i(rst_n), .baud_tick_i(baud_tick), .data_i(data),
    .valid_i(valid[1]), .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]),
    .tx_done_o(done[1]));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_TICKS(24)) dut2 (
    .clk_i(clk), .reset_i(rst_n), .baud_tick_i(baud_tick), .data_i(data),
    .valid_i(valid[2]), .ready_o(ready[2]), .tx_o(tx[2]), .busy_o(busy[2]),
    .tx_done_o(done[2]));
  uart_tx #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_TICKS(32)) dut3 (
    .clk_i(clk), .reset_i(rst_n), .baud_tick_i(baud_tick), .data_i(data),
    .valid_i(valid[3]), .ready_o(ready[3]), .tx_o(tx[3]), .busy_o(busy[3]),
    .tx_done_o(done[3]));

  // Expected line level per bit slot: [0]=start, [1..8]=data LSB-first,
  // then parity (if enabled), then stop.
  function automatic logic [11:0] model_line(input logic [7:0] d, input int pe, input int po);
    logic [11:0] l;
    int ones;
    l = '1;
    l[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      l[i+1] = d[i];
      ones += int'(d[i]);
    end
    if (pe != 0) l[9] = ((ones % 2) == 1) ^ (po != 0);
    return l;
  endfunction

  task automatic wait_ready(input int sel);
    int n = 0;
    while (ready[sel] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (ready[sel] !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_wait dut%0d: ready=%b required 1", sel, ready[sel]);
    end
  endtask

  // Starts just after the handshake edge; returns on the negedge where
  // tx_done_o is seen (or after the cycle budget).
  task automatic run_frame(input int sel, input logic [7:0] d, input bit inject, output int ticks);
    int nb, total, cyc, k, dones, mid, inj_cyc;
    logic [11:0] exp_line;
    nb = 1 + 8 + PE[sel];
    total = nb * ST + SP[sel];
    exp_line = model_line(d, PE[sel], PO[sel]);
    ticks = 0; cyc = 0; k = 0; dones = 0; inj_cyc = -1;
    while (dones == 0 && cyc < 3000) begin
      @(posedge clk);
      if (baud_tick) ticks++;
      @(negedge clk);
      cyc++;
      if (inject && inj_cyc < 0 && ticks == 40) begin
        data = 8'hFF;
        valid[sel] = 1'b1;
        inj_cyc = cyc;
      end else if (inj_cyc >= 0 && cyc == inj_cyc + 1) begin
        valid[sel] = 1'b0;
      end
      if (k <= nb) begin
        mid = (k < nb) ? (k * ST + ST / 2) : (nb * ST + SP[sel] / 2);
        if (ticks >= mid) begin
          vectors++;
          if (tx[sel] !== exp_line[k]) begin
            miscompares++;
            $display("FAIL line_bit%0d dut%0d data=%h: tx=%b required %b", k, sel, d, tx[sel], exp_line[k]);
          end
          k++;
        end
      end
      if (done[sel] === 1'b1) begin
        dones++;
        vectors++;
        if (ticks != total) begin
          miscompares++;
          $display("FAIL done_tick dut%0d data=%h: done at tick %0d required %0d", sel, d, ticks, total);
        end
      end else begin
        vectors++;
        if (busy[sel] !== 1'b1) begin
          miscompares++;
          $display("FAIL busy_frame dut%0d tick %0d: busy=%b required 1", sel, ticks, busy[sel]);
        end
      end
    end
    vectors++;
    if (dones != 1) begin
      miscompares++;
      $display("FAIL done_timeout dut%0d data=%h: done pulses %0d required 1", sel, d, dones);
    end
    vectors++;
    if (k != nb + 1) begin
      miscompares++;
      $display("FAIL bit_samples dut%0d: sampled %0d bits required %0d", sel, k, nb + 1);
    end
    vectors++;
    if (ready[sel] !== 1'b1 || busy[sel] !== 1'b0) begin
      miscompares++;
      $display("FAIL post_done dut%0d: ready=%b busy=%b required 1 0", sel, ready[sel], busy[sel]);
    end
  endtask

  task automatic check_idle(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vectors++;
      if (done[sel] !== 1'b0 || tx[sel] !== 1'b1) begin
        miscompares++;
        $display("FAIL idle dut%0d: done=%b tx=%b required 0 1", sel, done[sel], tx[sel]);
      end
    end
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input bit inject);
    int t;
    wait_ready(sel);
    data = d;
    valid[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[sel] = 1'b0;
    run_frame(sel, d, inject, t);
    check_idle(sel, 6);
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (ready !== 4'hF || tx !== 4'hF || busy !== 4'h0 || done !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b tx=%b busy=%b done=%b required 1111 1111 0000 0000",
               ready, tx, busy, done);
    end
  endtask

  task automatic test_basic();
    send_frame(0, 8'hCC, 0);
  endtask

  task automatic test_parity();
    send_frame(1, 8'h07, 0);
    send_frame(2, 8'h07, 0);
  endtask

  task automatic test_back_to_back();
    int t;
    wait_ready(0);
    data = 8'h55;
    valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data = 8'hAA;
    run_frame(0, 8'h55, 0, t);
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    vectors++;
    if (busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept: busy=%b required 1", busy[0]);
    end
    run_frame(0, 8'hAA, 0, t);
    check_idle(0, 6);
  endtask

  task automatic test_ignore_valid();
    send_frame(0, 8'h12, 1);
  endtask

  task automatic test_reset_midframe();
    int ticks = 0;
    int n = 0;
    wait_ready(0);
    data = 8'hA5;
    valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    while (ticks < 70 && n < 1000) begin
      @(posedge clk);
      if (baud_tick) ticks++;
      @(negedge clk);
      n++;
    end
    vectors++;
    if (tx[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_reset_bit3: tx=%b required 0", tx[0]);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b1 || done[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: tx=%b busy=%b ready=%b done=%b required 1 0 1 0",
               tx[0], busy[0], ready[0], done[0]);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_idle(0, 100);
    send_frame(0, 8'hA5, 0);
  endtask

  task automatic test_stop32();
    send_frame(3, 8'h00, 0);
  endtask

  task automatic test_random();
    int sel;
    for (int i = 0; i < 10; i++) begin
      sel = int'($urandom_range(0, 3));
      repeat ($urandom_range(0, 7)) @(negedge clk);
      send_frame(sel, 8'($urandom), 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_ignore_valid();
    test_reset_midframe();
    test_stop32();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
